// File: rtl/dram_wb_arbiter_if.sv
// Wishbone classic bundle between NUM_MASTERS requesters and the shared LiteDRAM user port.
// slave is the arbiter's view; master is the requesters-plus-DRAM-port environment.
interface dram_wb_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADR_W       = 25,
  parameter int DAT_W       = 256
);
  logic [NUM_MASTERS-1:0]         m_cyc;
  logic [NUM_MASTERS-1:0]         m_stb;
  logic [NUM_MASTERS-1:0]         m_we;
  logic [NUM_MASTERS*ADR_W-1:0]   m_adr;
  logic [NUM_MASTERS*DAT_W-1:0]   m_dat_w;
  logic [NUM_MASTERS*DAT_W/8-1:0] m_sel;
  logic [NUM_MASTERS-1:0]         m_ack;
  logic [NUM_MASTERS-1:0]         m_err;
  logic [DAT_W-1:0]               m_dat_r;

  logic                           s_cyc;
  logic                           s_stb;
  logic                           s_we;
  logic [ADR_W-1:0]               s_adr;
  logic [DAT_W-1:0]               s_dat_w;
  logic [DAT_W/8-1:0]             s_sel;
  logic                           s_ack;
  logic                           s_err;
  logic [DAT_W-1:0]               s_dat_r;

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    output m_ack, m_err, m_dat_r,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    input  s_ack, s_err, s_dat_r
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    input  m_ack, m_err, m_dat_r,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    output s_ack, s_err, s_dat_r
  );
endinterface

// File: rtl/dram_wb_arbiter.sv
// Round-robin Wishbone arbiter onto the LiteDRAM user port; grant 1 cycle after request, held for the whole cyc, 1-cycle bubble between owners.
// Optional stb-without-ack watchdog (err pulse, sticky timeout, DRAIN state) under `DRAM_WB_ARB_TIMEOUT_EN.
module dram_wb_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int ADR_W          = 25,
  parameter int DAT_W          = 256,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   user_clk,
  input  logic                   user_rst,
  dram_wb_arbiter_if.slave       bus,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   busy,
  output logic                   timeout
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int SEL_W = DAT_W / 8;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("dram_wb_arbiter: parameter out of range");
  end

`ifdef DRAM_WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DRAIN} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             timeout_d, timeout_q;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT} state_t;
`endif

  state_t                 state_d, state_q;
  logic [NUM_MASTERS-1:0] grant_d, grant_q;
  logic [IDX_W-1:0]       last_d, last_q;

  logic [NUM_MASTERS-1:0] req;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic                   owner_cyc;
  logic                   owner_stb;

  assign req       = bus.m_cyc & bus.m_stb;
  // While a grant is held, last_q is the owner's index.
  assign owner_cyc = bus.m_cyc[last_q];
  assign owner_stb = bus.m_stb[last_q];

  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = last_q;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      j = (int'(last_q) + k) % NUM_MASTERS;
      if (!pick_found && req[IDX_W'(j)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.s_sel   = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
`ifdef DRAM_WB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          grant_d = NUM_MASTERS'(1) << pick_idx;
          last_d  = pick_idx;
`ifdef DRAM_WB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        bus.s_cyc   = owner_cyc;
        bus.s_stb   = owner_stb;
        bus.s_we    = bus.m_we[last_q];
        bus.s_adr   = bus.m_adr[int'(last_q)*ADR_W +: ADR_W];
        bus.s_dat_w = bus.m_dat_w[int'(last_q)*DAT_W +: DAT_W];
        bus.s_sel   = bus.m_sel[int'(last_q)*SEL_W +: SEL_W];
        bus.m_ack   = grant_q & {NUM_MASTERS{bus.s_ack}};
        bus.m_err   = grant_q & {NUM_MASTERS{bus.s_err}};
        if (!owner_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
`ifdef DRAM_WB_ARB_TIMEOUT_EN
        else if (bus.s_ack || bus.s_err) begin
          cnt_d = '0;
        end else if (owner_stb) begin
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.m_err = grant_q;
            timeout_d = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
`ifdef DRAM_WB_ARB_TIMEOUT_EN
      // Port is fenced off; any straggling ack from the DRAM side is swallowed.
      ST_DRAIN: begin
        if (!owner_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef DRAM_WB_ARB_TIMEOUT_EN
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign bus.m_dat_r = bus.s_dat_r;
  assign grant       = grant_q;
  assign busy        = |grant_q;
endmodule
